// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole round sequencer.
//   state_t    : round FSM states
//   LFSR_SEED  : LFSR value after reset (must be non-zero)
//   LFSR_TAPS  : feedback mask for taps 16,14,13,11 (bits 15,13,12,10)
//   clog2()    : coordinate width for a given grid side
package mole_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    SHOW = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int clog2(input int v);
    int w;
    w = 0;
    while ((1 << w) < v) w++;
    return w;
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; supplies the raw mole coordinates.
//   clk, rst_n : clock, async active-low reset (reloads LFSR_SEED)
//   rnd_row    : lfsr[CW-1:0]
//   rnd_col    : lfsr[8 +: CW]
// Only the coordinate slices leave the block; the full state stays inside.
module mole_lfsr
  import mole_pkg::*;
#(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] rnd_row,
  output logic [CW-1:0] rnd_col
);

  logic [15:0] lfsr;
  logic        fb;

  // XOR of the tapped bits; a non-zero seed never reaches the all-zero state.
  assign fb = ^(lfsr & LFSR_TAPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= {lfsr[14:0], fb};
  end

  assign rnd_row = lfsr[CW-1:0];
  assign rnd_col = lfsr[8 +: CW];

endmodule

// File: rtl/mole_round_sequencer.sv
// Sequences one whack-a-mole round: random mole placement, show/gap timing,
// key-press hit detection, one hit or miss pulse per mole, show-time speed-up.
//   clk, rst_n            : clock, async active-low reset
//   tick                  : time-base strobe (one count per cycle it is high)
//   start, abort          : round start request / abort (abort dominates)
//   key_valid/row/col     : debounced key press strobe and position
//   mole_vis/row/col      : current mole shown and its position
//   hit_pulse/miss_pulse  : one-cycle resolution of the current mole
//   round_done            : one cycle after the last mole resolves
//   busy                  : FSM not idle
//   moles_left, show_len  : unresolved moles, show time for the next mole
// All outputs are registered.
module mole_round_sequencer
  import mole_pkg::*;
#(
  parameter int GRID         = 4,
  parameter int SHOW_TICKS   = 25,
  parameter int GAP_TICKS    = 5,
  parameter int MIN_SHOW     = 5,
  parameter int STEP         = 2,
  parameter int SPEEDUP_HITS = 5,
  parameter int MOLES        = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic       abort,
  input  logic       key_valid,
  input  logic [2:0] key_row,
  input  logic [2:0] key_col,
  output logic       mole_vis,
  output logic [2:0] mole_row,
  output logic [2:0] mole_col,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       round_done,
  output logic       busy,
  output logic [7:0] moles_left,
  output logic [7:0] show_len
);

  localparam int CW = clog2(GRID);

  state_t          state, state_n;
  logic [7:0]      cnt, cnt_n;
  logic [7:0]      hit_cnt, hit_cnt_n;
  logic            vis_n, hit_n, miss_n, done_n;
  logic [2:0]      row_n, col_n;
  logic [7:0]      ml_n, sl_n;
  logic [CW-1:0]   rnd_row, rnd_col, spawn_col;
  logic            key_match, expire;

  mole_lfsr #(.CW(CW)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .rnd_row (rnd_row),
    .rnd_col (rnd_col)
  );

  // Never spawn on top of the previous mole: nudge the column (wraps, GRID is 2^n).
  always_comb begin
    spawn_col = rnd_col;
    if (rnd_row == mole_row[CW-1:0] && rnd_col == mole_col[CW-1:0])
      spawn_col = rnd_col + 1'b1;
  end

  assign key_match = key_valid && (key_row == mole_row) && (key_col == mole_col);
  assign expire    = tick && (cnt <= 8'd1);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hit_cnt_n = hit_cnt;
    vis_n     = mole_vis;
    row_n     = mole_row;
    col_n     = mole_col;
    ml_n      = moles_left;
    sl_n      = show_len;
    hit_n     = 1'b0;
    miss_n    = 1'b0;
    done_n    = 1'b0;
    if (abort) begin
      state_n   = IDLE;
      vis_n     = 1'b0;
      cnt_n     = '0;
      hit_cnt_n = '0;
      ml_n      = '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          state_n   = GAP;
          ml_n      = 8'(MOLES);
          sl_n      = 8'(SHOW_TICKS);
          cnt_n     = 8'(GAP_TICKS);
          hit_cnt_n = '0;
        end
        GAP: if (tick) begin
          if (cnt <= 8'd1) begin
            state_n = SHOW;
            row_n   = 3'(rnd_row);
            col_n   = 3'(spawn_col);
            cnt_n   = show_len;
            vis_n   = 1'b1;
          end else begin
            cnt_n = cnt - 8'd1;
          end
        end
        SHOW: begin
          if (key_match || expire) begin
            // A hit in the expiring cycle still counts as a hit.
            hit_n  = key_match;
            miss_n = !key_match;
            vis_n  = 1'b0;
            ml_n   = moles_left - 8'd1;
            if (key_match) begin
              if (hit_cnt + 8'd1 == 8'(SPEEDUP_HITS)) begin
                hit_cnt_n = '0;
                sl_n = ({1'b0, show_len} >= 9'(MIN_SHOW + STEP)) ?
                       show_len - 8'(STEP) : 8'(MIN_SHOW);
              end else begin
                hit_cnt_n = hit_cnt + 8'd1;
              end
            end
            if (moles_left <= 8'd1) begin
              state_n = DONE;
            end else begin
              state_n = GAP;
              cnt_n   = 8'(GAP_TICKS);
            end
          end else if (tick) begin
            cnt_n = cnt - 8'd1;
          end
        end
        DONE: begin
          state_n = IDLE;
          done_n  = 1'b1;
          ml_n    = '0;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      hit_cnt    <= '0;
      mole_vis   <= 1'b0;
      mole_row   <= '0;
      mole_col   <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      round_done <= 1'b0;
      busy       <= 1'b0;
      moles_left <= '0;
      show_len   <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      hit_cnt    <= hit_cnt_n;
      mole_vis   <= vis_n;
      mole_row   <= row_n;
      mole_col   <= col_n;
      hit_pulse  <= hit_n;
      miss_pulse <= miss_n;
      round_done <= done_n;
      busy       <= (state_n != IDLE);
      moles_left <= ml_n;
      show_len   <= sl_n;
    end
  end

endmodule

// File: tb/tb_mole_round_sequencer.sv
module tb_mole_round_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, abort = 1'b0;
  logic       start = 1'b0, key_valid = 1'b0;
  logic [2:0] key_row = '0, key_col = '0;
  logic       start2 = 1'b0, key_valid2 = 1'b0;
  logic [2:0] key_row2 = '0, key_col2 = '0;

  logic       mole_vis, hit_pulse, miss_pulse, round_done, busy;
  logic [2:0] mole_row, mole_col;
  logic [7:0] moles_left, show_len;
  logic       mole_vis2, hit_pulse2, miss_pulse2, round_done2, busy2;
  logic [2:0] mole_row2, mole_col2;
  logic [7:0] moles_left2, show_len2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mole_round_sequencer dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .abort(abort),
    .key_valid(key_valid), .key_row(key_row), .key_col(key_col),
    .mole_vis(mole_vis), .mole_row(mole_row), .mole_col(mole_col),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .round_done(round_done),
    .busy(busy), .moles_left(moles_left), .show_len(show_len)
  );

  // Short-round instance: 3 moles, one hit per speed-up, floor reached quickly.
  mole_round_sequencer #(
    .GRID(4), .SHOW_TICKS(8), .GAP_TICKS(2), .MIN_SHOW(5), .STEP(2),
    .SPEEDUP_HITS(1), .MOLES(3)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start2), .abort(abort),
    .key_valid(key_valid2), .key_row(key_row2), .key_col(key_col2),
    .mole_vis(mole_vis2), .mole_row(mole_row2), .mole_col(mole_col2),
    .hit_pulse(hit_pulse2), .miss_pulse(miss_pulse2), .round_done(round_done2),
    .busy(busy2), .moles_left(moles_left2), .show_len(show_len2)
  );

  // Reference LFSR; m_prev is the value the DUT saw in the previous cycle.
  logic [15:0] m, m_prev;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m      <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m;
      m      <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic wait_spawn(input int which);
    int n;
    n = 0;
    while (((which == 0) ? mole_vis : mole_vis2) !== 1'b1 && n < 300) begin
      pulse_tick();
      n++;
    end
    chk("spawn", (which == 0) ? mole_vis : mole_vis2, 1);
  endtask

  task automatic press(input int which, input logic [2:0] r, input logic [2:0] c);
    if (which == 0) begin key_valid = 1'b1; key_row = r; key_col = c; end
    else            begin key_valid2 = 1'b1; key_row2 = r; key_col2 = c; end
    cyc();
    key_valid = 1'b0;
    key_valid2 = 1'b0;
  endtask

  task automatic do_hit(input int which);
    wait_spawn(which);
    if (which == 0) begin
      press(0, mole_row, mole_col);
      chk("hit", {hit_pulse, miss_pulse, mole_vis}, 3'b100);
    end else begin
      press(1, mole_row2, mole_col2);
      chk("hit2", {hit_pulse2, miss_pulse2, mole_vis2}, 3'b100);
    end
  endtask

  initial begin
    logic [1:0] er, ec, pr, pc;
    bit have_prev;

    // Reset state
    cyc(); cyc();
    chk("rst_outs", {mole_vis, mole_row, mole_col, hit_pulse, miss_pulse,
                     round_done, busy, moles_left, show_len}, 0);
    chk("rst_lfsr", dut.u_lfsr.lfsr, 16'hACE1);
    rst_n = 1'b1;
    cyc();

    // 1: reset in the middle of SHOW
    start = 1'b1; cyc(); start = 1'b0;
    wait_spawn(0);
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {mole_vis, mole_row, mole_col, hit_pulse, miss_pulse,
                        round_done, busy, moles_left, show_len}, 0);
    chk("midrst_lfsr", dut.u_lfsr.lfsr, 16'hACE1);
    cyc();
    rst_n = 1'b1;
    cyc();

    // 2: start, 5 gap ticks, hit latency
    start = 1'b1; cyc(); start = 1'b0;
    chk("start_state", {busy, mole_vis, moles_left, show_len}, {1'b1, 1'b0, 8'd20, 8'd25});
    for (int i = 0; i < 4; i++) begin
      pulse_tick();
      chk("gap_blank", mole_vis, 0);
    end
    pulse_tick();
    chk("gap_5th", mole_vis, 1);
    chk("coord_rng", {mole_row < 3'd4, mole_col < 3'd4}, 2'b11);
    press(0, mole_row, mole_col);
    chk("hit_n1", {hit_pulse, miss_pulse, mole_vis, moles_left}, {3'b100, 8'd19});
    cyc();
    chk("hit_once", hit_pulse, 0);
    press(0, mole_row, mole_col);
    chk("repress", {hit_pulse, miss_pulse}, 2'b00);

    // 3: expiry after 25 ticks, then hit on the expiring tick
    wait_spawn(0);
    for (int i = 0; i < 24; i++) pulse_tick();
    chk("show_24", {mole_vis, miss_pulse}, 2'b10);
    pulse_tick();
    chk("miss_25", {miss_pulse, hit_pulse, mole_vis, moles_left}, {3'b100, 8'd18});
    cyc();
    chk("miss_once", miss_pulse, 0);
    wait_spawn(0);
    for (int i = 0; i < 24; i++) pulse_tick();
    tick = 1'b1;
    press(0, mole_row, mole_col);
    tick = 1'b0;
    chk("hit_vs_exp", {hit_pulse, miss_pulse, moles_left}, {2'b10, 8'd17});

    // 4: wrong keys ignored; fifth hit speeds up; shorter show applied next mole
    wait_spawn(0);
    press(0, mole_row ^ 3'd1, mole_col);
    chk("wrong_row", {hit_pulse, miss_pulse, mole_vis}, 3'b001);
    press(0, mole_row, mole_col ^ 3'd2);
    chk("wrong_col", {hit_pulse, miss_pulse, mole_vis}, 3'b001);
    press(0, mole_row, mole_col);
    chk("hit3", {hit_pulse, show_len}, {1'b1, 8'd25});
    do_hit(0);
    do_hit(0);
    chk("speedup", {moles_left, show_len}, {8'd14, 8'd23});
    wait_spawn(0);
    for (int i = 0; i < 22; i++) pulse_tick();
    chk("show23_22", {mole_vis, miss_pulse}, 2'b10);
    pulse_tick();
    chk("miss_23", {miss_pulse, moles_left}, {1'b1, 8'd13});
    for (int i = 0; i < 13; i++) do_hit(0);
    chk("end_round", {busy, moles_left, show_len}, {1'b1, 8'd0, 8'd19});
    cyc();
    chk("done_pulse", {round_done, busy}, 2'b10);
    cyc();
    chk("done_once", {round_done, busy}, 2'b00);

    // 6: abort in GAP (with start) and in SHOW (with a matching key and tick)
    start = 1'b1; cyc(); start = 1'b0;
    pulse_tick(); pulse_tick();
    abort = 1'b1; start = 1'b1;
    cyc();
    abort = 1'b0; start = 1'b0;
    chk("abort_gap", {busy, mole_vis, hit_pulse, miss_pulse, round_done, moles_left}, 0);
    cyc();
    chk("abort_start", busy, 0);
    start = 1'b1; cyc(); start = 1'b0;
    wait_spawn(0);
    abort = 1'b1; tick = 1'b1;
    press(0, mole_row, mole_col);
    abort = 1'b0; tick = 1'b0;
    chk("abort_show", {busy, mole_vis, hit_pulse, miss_pulse, round_done, moles_left}, 0);
    cyc();
    chk("abort_quiet", {hit_pulse, miss_pulse, round_done}, 0);

    // 5: three-mole round; start in SHOW ignored; show_len floors at 5
    start2 = 1'b1; cyc(); start2 = 1'b0;
    chk("r2_start", {busy2, moles_left2, show_len2}, {1'b1, 8'd3, 8'd8});
    wait_spawn(1);
    start2 = 1'b1; cyc(); start2 = 1'b0;
    chk("r2_start_show", {mole_vis2, moles_left2}, {1'b1, 8'd3});
    press(1, mole_row2, mole_col2);
    chk("r2_hit1", {hit_pulse2, moles_left2, show_len2}, {1'b1, 8'd2, 8'd6});
    wait_spawn(1);
    for (int i = 0; i < 5; i++) pulse_tick();
    chk("r2_show5", {mole_vis2, miss_pulse2}, 2'b10);
    pulse_tick();
    chk("r2_miss", {miss_pulse2, hit_pulse2, moles_left2, show_len2}, {2'b10, 8'd1, 8'd6});
    do_hit(1);
    chk("r2_last", {moles_left2, show_len2, busy2, round_done2}, {8'd0, 8'd5, 2'b10});
    cyc();
    chk("r2_done", {round_done2, busy2, hit_pulse2, miss_pulse2}, 4'b1000);
    cyc();
    chk("r2_done_once", round_done2, 0);
    start2 = 1'b1; cyc(); start2 = 1'b0;
    do_hit(1);
    chk("r3_sl1", show_len2, 8'd6);
    do_hit(1);
    chk("r3_sl2", show_len2, 8'd5);
    do_hit(1);
    chk("r3_floor", show_len2, 8'd5);
    cyc(); cyc();

    // 6: 1000 moles, positions follow the LFSR and never repeat back-to-back
    have_prev = 1'b0;
    pr = '0; pc = '0;
    for (int r = 0; r < 50; r++) begin
      start = 1'b1; cyc(); start = 1'b0;
      for (int k = 0; k < 20; k++) begin
        wait_spawn(0);
        chk("rng_lim", {mole_row < 3'd4, mole_col < 3'd4}, 2'b11);
        if (have_prev) begin
          er = m_prev[1:0];
          ec = m_prev[9:8];
          if (er == pr && ec == pc) ec = ec + 2'd1;
          chk("pos_row", mole_row, {1'b0, er});
          chk("pos_col", mole_col, {1'b0, ec});
          chk("pos_new", (mole_row[1:0] != pr) || (mole_col[1:0] != pc), 1);
        end
        pr = mole_row[1:0];
        pc = mole_col[1:0];
        have_prev = 1'b1;
        press(0, mole_row, mole_col);
      end
      cyc();
      chk("run_done", round_done, 1);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
